// File: rtl/sram_req_scheduler.sv
// rtl/sram_req_scheduler.sv - arbitrates inst/data SRAM-like requesters onto one bridge request port
// Optional feature macro: SCHED_ROUND_ROBIN_EN (round-robin grant between inst and data sides)
module sram_req_scheduler #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  logic        clk,
  input  logic        resetn,
  // inst side (read only)
  input  logic        i_req,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  // data side
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  // bridge request port
  output logic        dn_req,
  output logic        dn_wr,
  output logic        dn_id,
  output logic [1:0]  dn_size,
  output logic [31:0] dn_addr,
  output logic [3:0]  dn_wstrb,
  output logic [31:0] dn_wdata,
  input  logic        dn_addr_ok,
  // bridge responses
  input  logic        dn_rvalid,
  input  logic        dn_rid,
  input  logic [31:0] dn_rdata,
  input  logic        dn_bvalid,
  output logic        err_underflow
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  // outstanding transaction counters and sticky error
  logic [CNT_W-1:0] r_rd_i_cnt;
  logic [CNT_W-1:0] r_rd_d_cnt;
  logic [CNT_W-1:0] r_wr_cnt;
  logic             r_err;

  logic w_i_elig;
  logic w_d_elig;
  logic w_prio_d;
  logic w_gnt_d;
  logic w_gnt_i;
  logic w_contended;

  logic w_i_issue;
  logic w_d_rd_issue;
  logic w_d_wr_issue;
  logic w_rd_i_retire;
  logic w_rd_d_retire;
  logic w_wr_retire;
  logic w_err_set;

  logic [CNT_W-1:0] w_rd_i_cnt_nxt;
  logic [CNT_W-1:0] w_rd_d_cnt_nxt;
  logic [CNT_W-1:0] w_wr_cnt_nxt;

  // issue and retire in the same cycle cancel; a retire at zero leaves the count at zero
  function automatic logic [CNT_W-1:0] f_cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic             issue,
                                                  input logic             retire);
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (issue && !retire) begin
      nxt = cnt + ONE;
    end else if (retire && !issue && (cnt != '0)) begin
      nxt = cnt - ONE;
    end
    return nxt;
  endfunction

  // data reads wait for every write to be acknowledged so a read never overtakes a write
  assign w_i_elig = i_req & (r_rd_i_cnt < MAX_CNT);
  assign w_d_elig = d_req & (d_wr ? (r_wr_cnt < MAX_CNT)
                                  : ((r_rd_d_cnt < MAX_CNT) & (r_wr_cnt == '0)));

  assign w_contended = w_i_elig & w_d_elig;
  assign w_gnt_d     = w_d_elig & (~w_i_elig | w_prio_d);
  assign w_gnt_i     = w_i_elig & ~w_gnt_d;

`ifdef SCHED_ROUND_ROBIN_EN
  logic r_prio_d;

  // after each contended transfer hand priority to the side that lost it
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_prio_d <= 1'b1;
    end else if (w_contended && dn_addr_ok) begin
      r_prio_d <= ~w_gnt_d;
    end
  end

  assign w_prio_d = r_prio_d;
`else
  assign w_prio_d = 1'b1;
`endif

  // request payload follows the granted side; idle port drives zeros
  always_comb begin
    dn_req   = w_i_elig | w_d_elig;
    dn_id    = w_gnt_d;
    dn_wr    = 1'b0;
    dn_size  = 2'b00;
    dn_addr  = 32'h0;
    dn_wstrb = 4'h0;
    dn_wdata = 32'h0;
    if (w_gnt_d) begin
      dn_wr    = d_wr;
      dn_size  = d_size;
      dn_addr  = d_addr;
      dn_wstrb = d_wstrb;
      dn_wdata = d_wdata;
    end else if (w_gnt_i) begin
      dn_size  = i_size;
      dn_addr  = i_addr;
    end
  end

  assign i_addr_ok = w_gnt_i & dn_addr_ok;
  assign d_addr_ok = w_gnt_d & dn_addr_ok;

  assign w_i_issue    = i_addr_ok;
  assign w_d_rd_issue = d_addr_ok & ~d_wr;
  assign w_d_wr_issue = d_addr_ok & d_wr;

  assign w_rd_i_retire = dn_rvalid & ~dn_rid;
  assign w_rd_d_retire = dn_rvalid & dn_rid;
  assign w_wr_retire   = dn_bvalid;

  // response routing by id; writes always belong to the data side
  assign i_data_ok = w_rd_i_retire;
  assign d_data_ok = w_rd_d_retire | w_wr_retire;
  assign i_rdata   = dn_rdata;
  assign d_rdata   = dn_rdata;

  assign w_rd_i_cnt_nxt = f_cnt_next(r_rd_i_cnt, w_i_issue, w_rd_i_retire);
  assign w_rd_d_cnt_nxt = f_cnt_next(r_rd_d_cnt, w_d_rd_issue, w_rd_d_retire);
  assign w_wr_cnt_nxt   = f_cnt_next(r_wr_cnt, w_d_wr_issue, w_wr_retire);

  // a response that matches nothing, or a data read and write ack colliding, is an error
  assign w_err_set = (w_rd_i_retire & (r_rd_i_cnt == '0))
                   | (w_rd_d_retire & (r_rd_d_cnt == '0))
                   | (w_wr_retire   & (r_wr_cnt   == '0))
                   | (dn_rvalid & dn_rid & dn_bvalid);

  // outstanding counters, visible the cycle after the transfer or response
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rd_i_cnt <= '0;
      r_rd_d_cnt <= '0;
      r_wr_cnt   <= '0;
    end else begin
      r_rd_i_cnt <= w_rd_i_cnt_nxt;
      r_rd_d_cnt <= w_rd_d_cnt_nxt;
      r_wr_cnt   <= w_wr_cnt_nxt;
    end
  end

  // sticky error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign err_underflow = r_err;

endmodule

// File: tb/tb_sram_req_scheduler.sv
// tb/tb_sram_req_scheduler.sv - scoreboard bench for sram_req_scheduler
module tb_sram_req_scheduler;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req;
  logic [1:0]  i_size;
  logic [31:0] i_addr;
  logic        i_addr_ok, i_data_ok;
  logic [31:0] i_rdata;
  logic        d_req, d_wr;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [3:0]  d_wstrb;
  logic [31:0] d_wdata;
  logic        d_addr_ok, d_data_ok;
  logic [31:0] d_rdata;
  logic        dn_req, dn_wr, dn_id;
  logic [1:0]  dn_size;
  logic [31:0] dn_addr;
  logic [3:0]  dn_wstrb;
  logic [31:0] dn_wdata;
  logic        dn_addr_ok;
  logic        dn_rvalid, dn_rid;
  logic [31:0] dn_rdata;
  logic        dn_bvalid;
  logic        err_underflow;

  always #5 clk = ~clk;

  sram_req_scheduler #(.MAX_OUTSTANDING(4), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_size(i_size), .i_addr(i_addr),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
    .d_wstrb(d_wstrb), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .dn_req(dn_req), .dn_wr(dn_wr), .dn_id(dn_id), .dn_size(dn_size),
    .dn_addr(dn_addr), .dn_wstrb(dn_wstrb), .dn_wdata(dn_wdata),
    .dn_addr_ok(dn_addr_ok),
    .dn_rvalid(dn_rvalid), .dn_rid(dn_rid), .dn_rdata(dn_rdata),
    .dn_bvalid(dn_bvalid), .err_underflow(err_underflow)
  );

  typedef struct {
    int          cyc;
    logic [63:0] val;
  } ev_t;

  ev_t q_ia[$];
  ev_t q_da[$];
  ev_t q_id[$];
  ev_t q_dd[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got 1 expected 0 (cycle %0d, nothing queued)", name, cyc);
  endtask

  task automatic push_ia(input logic [31:0] a);
    q_ia.push_back('{cyc, {31'b0, 1'b0, a}});
  endtask
  task automatic push_da(input logic [31:0] a);
    q_da.push_back('{cyc, {31'b0, 1'b1, a}});
  endtask
  task automatic push_id(input logic [31:0] v);
    q_id.push_back('{cyc, {32'b0, v}});
  endtask
  task automatic push_dd(input logic [31:0] v);
    q_dd.push_back('{cyc, {32'b0, v}});
  endtask

  // monitor: every handshake the DUT presents must match the head of its queue
  always @(negedge clk) begin : monitor
    ev_t e;
    if (resetn === 1'b1) begin
      if (i_addr_ok) begin
        if (q_ia.size() == 0) unexpected("i_addr_ok");
        else begin
          e = q_ia.pop_front();
          chk("i_addr_ok cycle", 64'(cyc), 64'(e.cyc));
          chk("i_addr_ok id/addr", {31'b0, dn_id, dn_addr}, e.val);
        end
      end
      if (d_addr_ok) begin
        if (q_da.size() == 0) unexpected("d_addr_ok");
        else begin
          e = q_da.pop_front();
          chk("d_addr_ok cycle", 64'(cyc), 64'(e.cyc));
          chk("d_addr_ok id/addr", {31'b0, dn_id, dn_addr}, e.val);
        end
      end
      if (i_data_ok) begin
        if (q_id.size() == 0) unexpected("i_data_ok");
        else begin
          e = q_id.pop_front();
          chk("i_data_ok cycle", 64'(cyc), 64'(e.cyc));
          chk("i_rdata", {32'b0, i_rdata}, e.val);
        end
      end
      if (d_data_ok) begin
        if (q_dd.size() == 0) unexpected("d_data_ok");
        else begin
          e = q_dd.pop_front();
          chk("d_data_ok cycle", 64'(cyc), 64'(e.cyc));
          chk("d_rdata", {32'b0, d_rdata}, e.val);
        end
      end
    end
  end

  task automatic idle();
    i_req = 0; i_size = 2'd2; i_addr = 0;
    d_req = 0; d_wr = 0; d_size = 2'd2; d_addr = 0; d_wstrb = 0; d_wdata = 0;
    dn_addr_ok = 1; dn_rvalid = 0; dn_rid = 0; dn_rdata = 0; dn_bvalid = 0;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    mid();
    nxt();
  endtask

  task automatic rsp(input logic rid, input logic [31:0] data);
    dn_rvalid = 1; dn_rid = rid; dn_rdata = data;
    if (rid) push_dd(data); else push_id(data);
    step();
    dn_rvalid = 0; dn_rid = 0; dn_rdata = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1;
    mid();
    chk("reset err_underflow", {63'b0, err_underflow}, 64'd0);
    chk("reset dn_req", {63'b0, dn_req}, 64'd0);
    chk("reset outputs", {60'b0, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}, 64'd0);
    nxt();

    // T1: single inst read, response three cycles later
    i_req = 1; i_addr = 32'h1C00_0000; push_ia(32'h1C00_0000);
    step();
    i_req = 0;
    step();
    step();
    rsp(1'b0, 32'hDEAD_BEEF);

    // T2: contention between inst and data reads
    i_req = 1; i_addr = 32'h0000_1000;
    d_req = 1; d_wr = 0; d_addr = 32'h0000_2000;
    push_da(32'h0000_2000);
    step();
    d_addr = 32'h0000_2004;
`ifdef SCHED_ROUND_ROBIN_EN
    push_ia(32'h0000_1000);
    step();
    i_req = 0;
    push_da(32'h0000_2004);
    step();
`else
    push_da(32'h0000_2004);
    step();
    d_req = 0;
    push_ia(32'h0000_1000);
    step();
`endif
    idle();
    rsp(1'b1, 32'h1111_1111);
    rsp(1'b1, 32'h2222_2222);
    rsp(1'b0, 32'h3333_3333);

    // T3: data read held behind an outstanding write; inst read not held
    d_req = 1; d_wr = 1; d_addr = 32'h80; d_wstrb = 4'hF; d_wdata = 32'hCAFE_F00D;
    push_da(32'h80);
    mid();
    chk("write dn_wr/wstrb/wdata", {27'b0, dn_wr, dn_wstrb, dn_wdata}, {27'b0, 1'b1, 4'hF, 32'hCAFE_F00D});
    nxt();
    d_wr = 0; d_addr = 32'h100; d_wstrb = 0; d_wdata = 0;
    i_req = 1; i_addr = 32'h1C00_0010; push_ia(32'h1C00_0010);
    mid();
    chk("RAW read held (inst busy)", {63'b0, d_addr_ok}, 64'd0);
    nxt();
    i_req = 0;
    mid();
    chk("RAW read held dn_req", {63'b0, dn_req}, 64'd0);
    nxt();
    dn_bvalid = 1; push_dd(32'h0);
    mid();
    chk("RAW read held on bvalid cycle", {63'b0, d_addr_ok}, 64'd0);
    nxt();
    dn_bvalid = 0;
    push_da(32'h100);
    step();
    d_req = 0;
    rsp(1'b0, 32'h4444_4444);
    rsp(1'b1, 32'h5555_5555);

    // T4: inst read capacity and same-cycle issue+retire
    i_req = 1;
    for (int k = 0; k < 4; k++) begin
      i_addr = 32'h200 + 32'(4 * k);
      push_ia(i_addr);
      step();
    end
    i_addr = 32'h210;
    mid();
    chk("cap held i_addr_ok", {63'b0, i_addr_ok}, 64'd0);
    chk("cap held dn_req", {63'b0, dn_req}, 64'd0);
    nxt();
    dn_rvalid = 1; dn_rid = 0; dn_rdata = 32'h6666_6666; push_id(32'h6666_6666);
    mid();
    chk("cap held during response", {63'b0, dn_req}, 64'd0);
    nxt();
    dn_rdata = 32'h7777_7777; push_id(32'h7777_7777); push_ia(32'h210);
    step();
    dn_rvalid = 0; dn_rdata = 0;
    i_addr = 32'h214; push_ia(32'h214);
    step();
    i_addr = 32'h218;
    mid();
    chk("cap held after issue+retire", {63'b0, i_addr_ok}, 64'd0);
    nxt();
    i_req = 0;
    for (int k = 0; k < 4; k++) rsp(1'b0, 32'h8000_0000 + 32'(k));

    // T5: data response with nothing outstanding
    mid();
    chk("err before underflow", {63'b0, err_underflow}, 64'd0);
    nxt();
    dn_rvalid = 1; dn_rid = 1; dn_rdata = 32'hBADB_AD00; push_dd(32'hBADB_AD00);
    mid();
    chk("err not yet visible", {63'b0, err_underflow}, 64'd0);
    nxt();
    idle();
    d_req = 1; d_addr = 32'h300; push_da(32'h300);
    mid();
    chk("err sticky set", {63'b0, err_underflow}, 64'd1);
    nxt();
    d_req = 0;
    step();
    mid();
    chk("err still set", {63'b0, err_underflow}, 64'd1);
    nxt();

    // T6: reset with reads outstanding
    i_req = 1;
    for (int k = 0; k < 4; k++) begin
      i_addr = 32'h400 + 32'(4 * k);
      push_ia(i_addr);
      step();
    end
    idle();
    resetn = 0;
    nxt();
    resetn = 1;
    mid();
    chk("post-reset err", {63'b0, err_underflow}, 64'd0);
    nxt();
    i_req = 1; i_addr = 32'h500; push_ia(32'h500);
    step();
    i_req = 0;
    d_req = 1; d_addr = 32'h600; push_da(32'h600);
    step();
    idle();
    rsp(1'b0, 32'h9999_0000);
    rsp(1'b1, 32'h9999_0001);
    mid();
    chk("no underflow after reset drain", {63'b0, err_underflow}, 64'd0);
    nxt();

    step();
    chk("i_addr_ok events left", 64'(q_ia.size()), 64'd0);
    chk("d_addr_ok events left", 64'(q_da.size()), 64'd0);
    chk("i_data_ok events left", 64'(q_id.size()), 64'd0);
    chk("d_data_ok events left", 64'(q_dd.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
